// File: rtl/per_handshake_rx.sv
// Peripheral-side four-phase send/ack receiver feeding a first-word-fall-through FIFO.
// per_ack is withheld while the FIFO is full, which stalls the sender.
module per_handshake_rx #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              per_clk,
   input  logic              per_rst,
   input  logic              per_send,
   input  logic [DATA_W-1:0] in_per_dados,
   output logic              per_ack,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic [CNT_W-1:0]  count,
   output logic              rd_underflow,
   input  logic              err_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic {IDLE, ACK} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              capture;
   logic              pop;

   // Acceptance uses the registered full, so a same-cycle pop never admits a write.
   always_comb begin
      full     = (count == CNT_W'(DEPTH));
      rd_valid = (count != '0);
      capture  = (state == IDLE) && per_send && !full;
      pop      = rd_en && rd_valid;
      rd_data  = rd_valid ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge per_clk or negedge per_rst) begin
      if (!per_rst) begin
         state   <= IDLE;
         per_ack <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  state   <= ACK;
                  per_ack <= 1'b1;
               end
            end
            ACK: begin
               if (!per_send) begin
                  state   <= IDLE;
                  per_ack <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               per_ack <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge per_clk or negedge per_rst) begin
      if (!per_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({capture, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge per_clk) begin
      if (capture) mem[wr_ptr] <= in_per_dados;
   end

   // A new underflow takes priority over a same-cycle clear.
   always_ff @(posedge per_clk or negedge per_rst) begin
      if (!per_rst)              rd_underflow <= 1'b0;
      else if (rd_en && !rd_valid) rd_underflow <= 1'b1;
      else if (err_clr)          rd_underflow <= 1'b0;
   end

endmodule

// File: doc/per_handshake_rx.md
# per_handshake_rx

Parametrised peripheral-side receiver for the CPU→peripheral send/ack link. It implements a full four-phase handshake on `per_send`/`per_ack` and captures `in_per_dados` into a DEPTH-entry first-word-fall-through FIFO. It stalls the sender by withholding `per_ack` while the buffer is full. The peripheral core drains the FIFO through a simple valid/read-enable port.

## Interface
- `DATA_W`, default 4: width of `in_per_dados` and `rd_data`.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `count`.

- `per_clk`  in  1  single clock; all state updates on its rising edge.
- `per_rst`  in  1  reset, asynchronous, active-low.
- `per_send`  in  1  sender request; high = data valid on `in_per_dados`.
- `in_per_dados`  in  DATA_W  sender data; sampled only on the accepting edge.
- `per_ack`  out  1  handshake acknowledge, registered.
- `rd_en`  in  1  pop the head entry when `rd_valid` = 1.
- `rd_data`  out  DATA_W  head entry (fall-through); 0 when `rd_valid` = 0.
- `rd_valid`  out  1  FIFO not empty.
- `full`  out  1  `count` == DEPTH.
- `count`  out  CNT_W  entries held, 0..DEPTH.
- `rd_underflow`  out  1  sticky; set by `rd_en` while empty.
- `err_clr`  in  1  synchronous clear of `rd_underflow`.

## Operation
- Reset (`per_rst` = 0, asynchronous) forces the following immediately:
  - state IDLE, `per_ack` = 0, read/write pointers 0, `count` = 0;
  - `full` = 0, `rd_valid` = 0, `rd_data` = 0, `rd_underflow` = 0.
  - FIFO memory contents are not reset.
- FSM states:
  - IDLE: if `per_send` = 1 and `full` = 0, write `in_per_dados` at the write pointer, advance it, set `per_ack` = 1, go to ACK. If `per_send` = 1 and `full` = 1, stay in IDLE with `per_ack` = 0 (backpressure). Otherwise stay.
  - ACK: `per_ack` held at 1 while `per_send` = 1. When `per_send` = 0, set `per_ack` = 0 and go to IDLE.
- One transfer per four-phase cycle. `per_send` held high never produces a second capture.
- The acceptance decision uses the registered `full` of the current cycle. A same-cycle pop does not admit a write into a full FIFO.
- Read side:
  - `rd_en` = 1 with `rd_valid` = 1 advances the read pointer.
  - `rd_en` = 1 with `rd_valid` = 0 changes nothing except setting `rd_underflow`.
- Simultaneous capture and pop: `count` is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is the authoritative full/empty indicator.
- `err_clr` and a new underflow in the same cycle: the set wins.
- Reset mid-handshake drops `per_ack` at once. If `per_send` is still high after reset release, it is a new request and is captured again.

## Timing
- Capture latency: `per_send` high at edge N (IDLE, not full) gives `per_ack` = 1, `rd_valid` = 1 and `count` +1 after edge N. `rd_data` shows the word in the same cycle.
- Release latency: `per_send` low at edge M (ACK) gives `per_ack` = 0 after edge M. The earliest next capture is edge M+1.
- Minimum handshake period: 2 cycles per word.
- Pop: `rd_en` at edge K updates `rd_data`, `count` and `rd_valid` after edge K.
- Backpressure release: when a pop at edge K clears `full`, a pending `per_send` is accepted at edge K+1.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.

## Test plan
Cases 1–5 use DATA_W=4, DEPTH=4; case 6 also runs at DATA_W=8.
1. Reset with `per_send` = 0, then one handshake with `in_per_dados` = 4'hA → `per_ack` rises one edge after `per_send`. `rd_valid` = 1, `rd_data` = 4'hA, `count` = 1. `per_ack` falls one edge after `per_send` drops.
2. Five back-to-back handshakes (1, 2, 3, 4, 5) with no reads → the first four are acked and `full` = 1, `count` = 4. The fifth holds `per_ack` = 0. One `rd_en` pops 1; the fifth is acked on the next edge and `count` returns to 4.
3. Hold `per_send` high for 10 cycles with data 4'h7 → exactly one capture, `count` = 1, `per_ack` high for the whole hold.
4. Capture and pop in the same cycle with `count` = 2 → `count` stays 2 and FIFO order is preserved across the pointer wrap. Read-out order must match write order over 12 words.
5. `rd_en` while empty → `rd_underflow` = 1 and `count` = 0. `err_clr` for one cycle → `rd_underflow` = 0. `err_clr` together with `rd_en` while empty → `rd_underflow` stays 1.
6. Assert `per_rst` = 0 asynchronously while in ACK with `count` = 3 → `per_ack`, `count`, `rd_valid` and `rd_data` are 0 before the next edge. Release reset with `per_send` still high → a new capture, `count` = 1.
